// File: rtl/stream_credit_receiver.sv
// Credit-throttled stream receiver: a Depth-entry circular buffer that hands
// payloads out over ready/valid and returns one registered credit per pop.

package cf_math_pkg;
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? $unsigned($clog2(num_idx)) : 32'd1;
  endfunction
endpackage

module stream_credit_receiver #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CntWidth  = cf_math_pkg::idx_width(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 credit_o,
  output logic [CntWidth-1:0]  usage_o,
  output logic                 overflow_o
);

  localparam int unsigned PtrWidth = cf_math_pkg::idx_width(Depth);
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
  localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]  usage_q, usage_d;
  logic                 credit_q, overflow_q;
  logic                 full, empty, push, pop;

  // Pointers wrap explicitly so Depth need not be a power of two.
  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  assign full  = (usage_q == DepthCnt);
  assign empty = (usage_q == '0);
  assign push  = in_valid_i & ~full;
  assign pop   = out_valid_o & out_ready_i;

  // Output comes only from registered state: no fall-through from in_*.
  assign out_valid_o = ~empty;
  assign out_data_o  = mem_q[rd_ptr_q];
  assign credit_o    = credit_q;
  assign usage_o     = usage_q;
  assign overflow_o  = overflow_q;

  always_comb begin
    // NOTE: default first so every path assigns usage_d and no latch is inferred.
    usage_d = usage_q;
    if (push && !pop) begin
      usage_d = usage_q + 1'b1;
    end else if (!push && pop) begin
      usage_d = usage_q - 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      usage_q    <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      usage_q  <= usage_d;
      credit_q <= pop;
      // A push while full means the transmitter ignored its credit count.
      if (in_valid_i && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // NOTE: payload storage is not reset; out_valid_o gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: tb/tb_stream_credit_receiver.sv
// Scoreboard bench for stream_credit_receiver at Depth=4 and Depth=3.
module tb_stream_credit_receiver;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, out_ready, out_valid, credit, overflow;
  logic [DW-1:0] in_data, out_data;
  logic [2:0]    usage;
  logic          in_valid3, out_ready3, out_valid3, credit3, overflow3;
  logic [DW-1:0] in_data3, out_data3;
  logic [1:0]    usage3;

  int n_vec = 0;
  int n_err = 0;
  int mdl_usage [2];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp3_q [$];

  stream_credit_receiver #(.Depth(4), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .credit_o(credit), .usage_o(usage), .overflow_o(overflow));

  stream_credit_receiver #(.Depth(3), .DataWidth(DW)) dut3 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid3), .in_data_i(in_data3),
    .out_valid_o(out_valid3), .out_ready_i(out_ready3), .out_data_o(out_data3),
    .credit_o(credit3), .usage_o(usage3), .overflow_o(overflow3));

  // One cycle on the selected instance (0: Depth=4, 1: Depth=3). Entered and
  // left at a falling edge; the scoreboard is fed on push and drained on pop.
  task automatic step(input bit sel, input logic v, input logic [DW-1:0] d, input logic r);
    int            depth;
    bit            fire, take;
    logic [DW-1:0] e, cd;
    logic          cv, cc;
    logic [2:0]    cu;
    depth = sel ? 3 : 4;
    if (sel) begin
      in_valid3 = v; in_data3 = d; out_ready3 = r; in_valid = 1'b0; out_ready = 1'b0;
    end else begin
      in_valid = v; in_data = d; out_ready = r; in_valid3 = 1'b0; out_ready3 = 1'b0;
    end
    cv   = sel ? out_valid3 : out_valid;
    cd   = sel ? out_data3 : out_data;
    fire = (mdl_usage[sel] != 0) && (r === 1'b1);
    take = (v === 1'b1) && (mdl_usage[sel] < depth);
    n_vec++;
    if (cv !== (mdl_usage[sel] != 0)) begin
      n_err++;
      $display("FAIL out_valid[%0d]: got %b expected %b", sel, cv, mdl_usage[sel] != 0);
    end
    if (fire) begin
      if (sel) e = exp3_q.pop_front();
      else     e = exp_q.pop_front();
      n_vec++;
      if (cd !== e) begin
        n_err++;
        $display("FAIL pop_data[%0d]: got %h expected %h", sel, cd, e);
      end
    end
    if (take) begin
      if (sel) exp3_q.push_back(d);
      else     exp_q.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    mdl_usage[sel] += int'(take) - int'(fire);
    cu = sel ? {1'b0, usage3} : usage;
    cc = sel ? credit3 : credit;
    n_vec++;
    if (cu !== 3'(mdl_usage[sel])) begin
      n_err++;
      $display("FAIL usage[%0d]: got %0d expected %0d", sel, cu, mdl_usage[sel]);
    end
    n_vec++;
    if (cc !== fire) begin
      n_err++;
      $display("FAIL credit[%0d]: got %b expected %b", sel, cc, fire);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp3_q.delete();
    mdl_usage[0] = 0;
    mdl_usage[1] = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({out_valid, credit, usage, overflow} !== 6'b0) begin
      n_err++;
      $display("FAIL reset4: got v=%b c=%b u=%0d o=%b expected all 0", out_valid, credit, usage, overflow);
    end
    n_vec++;
    if ({out_valid3, credit3, usage3, overflow3} !== 5'b0) begin
      n_err++;
      $display("FAIL reset3: got v=%b c=%b u=%0d o=%b expected all 0", out_valid3, credit3, usage3, overflow3);
    end
  endtask

  task automatic fill4(input logic [DW-1:0] base);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, base + DW'(i), 1'b0);
      n_vec++;
      if (usage !== 3'(i + 1) || credit !== 1'b0 || overflow !== 1'b0) begin
        n_err++;
        $display("FAIL fill_step%0d: got u=%0d c=%b o=%b expected u=%0d c=0 o=0", i, usage, credit, overflow, i + 1);
      end
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== base) begin
        n_err++;
        $display("FAIL fill_head%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, base);
      end
    end
  endtask

  task automatic test_fill();
    do_reset();
    fill4(32'hA000_0000);
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      n_vec++;
      if (credit !== 1'b1 || usage !== 3'(3 - i)) begin
        n_err++;
        $display("FAIL drain%0d: got c=%b u=%0d expected c=1 u=%0d", i, credit, usage, 3 - i);
      end
    end
    step(1'b0, 1'b0, '0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0 || credit !== 1'b0 || usage !== 3'd0) begin
      n_err++;
      $display("FAIL drain_end: got v=%b c=%b u=%0d expected v=0 c=0 u=0", out_valid, credit, usage);
    end
  endtask

  task automatic test_streaming(input bit sel);
    int pulses;
    logic [2:0] u;
    do_reset();
    step(sel, 1'b1, 32'h5000_0000, 1'b0);
    step(sel, 1'b1, 32'h5000_0001, 1'b0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(sel, 1'b1, 32'h5100_0000 + DW'(i), 1'b1);
      u = sel ? {1'b0, usage3} : usage;
      n_vec++;
      if (u !== 3'd2) begin
        n_err++;
        $display("FAIL stream_usage[%0d] cyc%0d: got %0d expected 2", sel, i, u);
      end
      if ((sel ? credit3 : credit) === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 20) begin
      n_err++;
      $display("FAIL stream_credits[%0d]: got %0d expected 20", sel, pulses);
    end
    for (int i = 0; i < 3; i++) step(sel, 1'b0, '0, 1'b1);
    n_vec++;
    if ((sel ? exp3_q.size() : exp_q.size()) != 0) begin
      n_err++;
      $display("FAIL stream_leftover[%0d]: got %0d entries expected 0", sel, sel ? exp3_q.size() : exp_q.size());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    fill4(32'hB000_0000);
    step(1'b0, 1'b1, 32'hEEEE_EEEE, 1'b0);
    n_vec++;
    if (overflow !== 1'b1 || usage !== 3'd4) begin
      n_err++;
      $display("FAIL ovf_push: got o=%b u=%0d expected o=1 u=4", overflow, usage);
    end
    step(1'b0, 1'b0, '0, 1'b0);
    n_vec++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky: got %b expected 1", overflow);
    end
    // Drain: the scoreboard holds only B0..B3, so a leaked E shows as bad data.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1);
    do_reset();
    fill4(32'hC000_0000);
    step(1'b0, 1'b1, 32'hEEEE_0001, 1'b1);
    n_vec++;
    if (overflow !== 1'b1 || usage !== 3'd3 || credit !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_pop: got o=%b u=%0d c=%b expected o=1 u=3 c=1", overflow, usage, credit);
    end
    step(1'b0, 1'b0, '0, 1'b0);
    n_vec++;
    if (credit !== 1'b0 || usage !== 3'd3) begin
      n_err++;
      $display("FAIL ovf_pop_single: got c=%b u=%0d expected c=0 u=3", credit, usage);
    end
  endtask

  task automatic test_reset_mid();
    // Entered with usage=3, overflow=1 left by test_overflow.
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    mdl_usage[0] = 0;
    n_vec++;
    if ({out_valid, credit, usage, overflow} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_mid: got v=%b c=%b u=%0d o=%b expected all 0", out_valid, credit, usage, overflow);
    end
  endtask

  task automatic test_random();
    int   tx_cred;
    logic v;
    do_reset();
    tx_cred = 4;
    for (int i = 0; i < 10000; i++) begin
      v = (tx_cred > 0) && ($urandom_range(0, 1) == 1);
      if (v) tx_cred--;
      step(1'b0, v, $urandom, ($urandom_range(0, 2) != 0));
      n_vec++;
      if (tx_cred + int'(usage) + int'(credit) != 4 || $isunknown({usage, credit})) begin
        n_err++;
        $display("FAIL conserve cyc%0d: got tx=%0d u=%0d c=%b sum expected 4", i, tx_cred, usage, credit);
      end
      n_vec++;
      if (overflow !== 1'b0) begin
        n_err++;
        $display("FAIL rand_ovf cyc%0d: got %b expected 0", i, overflow);
      end
      if (credit === 1'b1) tx_cred++;
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rand_leftover: got %0d entries expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_streaming(1'b0);
    test_streaming(1'b1);
    test_overflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
